// File: rtl/fact_core_pkg.sv
// Shared definitions for the factorial accelerator: register map, FSM states
// and OPDONE status bit positions.
package fact_core_pkg;

    localparam logic [4:0] OFS_OPSTART  = 5'd0;
    localparam logic [4:0] OFS_OPCLEAR  = 5'd1;
    localparam logic [4:0] OFS_OPDONE   = 5'd2;
    localparam logic [4:0] OFS_INTREN   = 5'd3;
    localparam logic [4:0] OFS_OPERAND  = 5'd4;
    localparam logic [4:0] OFS_RESULT_H = 5'd5;
    localparam logic [4:0] OFS_RESULT_L = 5'd6;
    localparam logic [4:0] OFS_LOWER    = 5'd8;

    localparam int unsigned BIT_DONE = 0;
    localparam int unsigned BIT_BUSY = 1;
    localparam int unsigned BIT_OVF  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_MUL,
        ST_STEP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/fact_core_p_if.sv
// Simple slave bus shared by the cores: select/write/address/data plus the
// core's level interrupt.
interface fact_core_p_if #(
    parameter int unsigned DW = 64,
    parameter int unsigned AW = 16
);
    logic          s_sel;
    logic          s_wr;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_din;
    logic [DW-1:0] s_dout;
    logic          interrupt;

    modport master (output s_sel, s_wr, s_addr, s_din, input s_dout, interrupt);
    modport slave  (input s_sel, s_wr, s_addr, s_din, output s_dout, interrupt);
endinterface

// File: rtl/fact_core_p_seq_mul.sv
// Iterative shift-add multiplier: a (2*DW) times b (DW), one bit of b per cycle.
// done is high during the cycle in which the last partial product is added.
module seq_mul #(
    parameter int unsigned DW = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            abort,
    input  logic [2*DW-1:0] a,
    input  logic [DW-1:0]   b,
    output logic            done,
    output logic [3*DW-1:0] product
);
    localparam int unsigned CW = $clog2(DW + 1);

    logic [3*DW-1:0] mcand;
    logic [DW-1:0]   mplier;
    logic [CW-1:0]   cnt;
    logic            busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            product <= '0;
        end else if (abort) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            mcand   <= {{DW{1'b0}}, a};
            mplier  <= b;
            product <= '0;
            cnt     <= CW'(DW);
            busy    <= 1'b1;
        end else if (busy) begin
            if (mplier[0])
                product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1))
                busy <= 1'b0;
        end
    end

    assign done = busy && (cnt == CW'(1));

endmodule

// File: rtl/fact_core_p.sv
// Bus-mapped accelerator computing the product of integers in (LOWER, OPERAND]
// with a 2*DW-bit result, sticky overflow and level interrupt.
module fact_core_p
    import fact_core_pkg::*;
#(
    parameter int unsigned DW = 64,
    parameter int unsigned AW = 16
) (
    input logic          clk,
    input logic          reset_n,
    fact_core_p_if.slave bus
);
    state_t          state, state_n;
    logic [DW-1:0]   operand, lower, intren, cnt, lo, lo_init, status;
    logic [2*DW-1:0] acc, result;
    logic [3*DW-1:0] product;
    logic [AW-1:0]   addr;
    logic [4:0]      ofs;
    logic            ovf, ovf_flag, ovf_next, mul_kick, mul_done;
    logic            wr, rd, start_req, clear_req, is_done, is_busy;

    assign addr      = bus.s_addr;
    assign ofs       = addr[7:3];
    assign wr        = bus.s_sel & bus.s_wr;
    assign rd        = bus.s_sel & ~bus.s_wr;
    assign start_req = wr && (ofs == OFS_OPSTART) && bus.s_din[0];
    assign clear_req = wr && (ofs == OFS_OPCLEAR) && bus.s_din[0];
    assign lo_init   = (lower == '0) ? DW'(1) : lower;
    assign ovf_next  = ovf | (|product[3*DW-1:2*DW]);
    assign is_done   = (state == ST_DONE);
    assign is_busy   = (state == ST_INIT) || (state == ST_MUL) || (state == ST_STEP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (start_req) state_n = ST_INIT;
            ST_INIT: state_n = (operand > lo_init) ? ST_MUL : ST_DONE;
            ST_MUL:  if (mul_done) state_n = ST_STEP;
            ST_STEP: state_n = ((cnt - DW'(1)) > lo) ? ST_MUL : ST_DONE;
            ST_DONE: state_n = ST_DONE;
            default: state_n = ST_IDLE;
        endcase
        if (clear_req) state_n = ST_IDLE;
    end

    // result/overflow are published on the edge that enters DONE, so they are
    // visible in the first DONE cycle together with the done status bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            operand  <= '0;
            lower    <= '0;
            intren   <= '0;
            cnt      <= '0;
            lo       <= '0;
            acc      <= '0;
            result   <= (2*DW)'(1);
            ovf      <= 1'b0;
            ovf_flag <= 1'b0;
            mul_kick <= 1'b0;
        end else begin
            mul_kick <= (state != ST_MUL) && (state_n == ST_MUL);
            if (wr && (ofs == OFS_INTREN))
                intren <= bus.s_din;
            if (clear_req) begin
                acc      <= (2*DW)'(1);
                result   <= (2*DW)'(1);
                ovf      <= 1'b0;
                ovf_flag <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (wr && (ofs == OFS_OPERAND)) operand <= bus.s_din;
                        if (wr && (ofs == OFS_LOWER))   lower   <= bus.s_din;
                    end
                    ST_INIT: begin
                        acc <= (2*DW)'(1);
                        cnt <= operand;
                        lo  <= lo_init;
                        ovf <= 1'b0;
                        if (state_n == ST_DONE) begin
                            result   <= (2*DW)'(1);
                            ovf_flag <= 1'b0;
                        end
                    end
                    ST_STEP: begin
                        acc <= product[2*DW-1:0];
                        ovf <= ovf_next;
                        cnt <= cnt - DW'(1);
                        if (state_n == ST_DONE) begin
                            result   <= product[2*DW-1:0];
                            ovf_flag <= ovf_next;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    seq_mul #(.DW(DW)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mul_kick),
        .abort   (clear_req),
        .a       (acc),
        .b       (cnt),
        .done    (mul_done),
        .product (product)
    );

    always_comb begin
        status           = '0;
        status[BIT_DONE] = is_done;
        status[BIT_BUSY] = is_busy;
        status[BIT_OVF]  = ovf_flag;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.s_dout <= '0;
        end else if (rd) begin
            case (ofs)
                OFS_OPDONE:   bus.s_dout <= status;
                OFS_INTREN:   bus.s_dout <= intren;
                OFS_OPERAND:  bus.s_dout <= operand;
                OFS_RESULT_H: bus.s_dout <= result[2*DW-1:DW];
                OFS_RESULT_L: bus.s_dout <= result[DW-1:0];
                OFS_LOWER:    bus.s_dout <= lower;
                default:      bus.s_dout <= '0;
            endcase
        end
    end

    assign bus.interrupt = intren[0] & is_done;

endmodule

// File: tb/tb_fact_core_p.sv
// Bench for fact_core_p: DW=16 and DW=64 instances, table vectors, random
// operands against an arithmetic reference model, and abort/reset sequences.
module tb_fact_core_p;
    import fact_core_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    fact_core_p_if #(.DW(16), .AW(16)) bus16 ();
    fact_core_p_if #(.DW(64), .AW(16)) bus64 ();

    fact_core_p #(.DW(16), .AW(16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus16));
    fact_core_p #(.DW(64), .AW(16)) dut64 (.clk(clk), .reset_n(reset_n), .bus(bus64));

    typedef struct {
        logic [63:0] op;
        logic [63:0] low;
        logic [63:0] exp_h;
        logic [63:0] exp_l;
        logic [63:0] exp_st;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic bus_wr(input int which, input logic [4:0] o, input logic [63:0] d);
        if (which == 0) begin
            bus16.s_sel = 1'b1; bus16.s_wr = 1'b1;
            bus16.s_addr = {8'b0, o, 3'b0}; bus16.s_din = d[15:0];
        end else begin
            bus64.s_sel = 1'b1; bus64.s_wr = 1'b1;
            bus64.s_addr = {8'b0, o, 3'b0}; bus64.s_din = d;
        end
        @(posedge clk); #1;
        bus16.s_sel = 1'b0; bus64.s_sel = 1'b0;
    endtask

    task automatic bus_rd(input int which, input logic [4:0] o, output logic [63:0] d);
        if (which == 0) begin
            bus16.s_sel = 1'b1; bus16.s_wr = 1'b0; bus16.s_addr = {8'b0, o, 3'b0};
        end else begin
            bus64.s_sel = 1'b1; bus64.s_wr = 1'b0; bus64.s_addr = {8'b0, o, 3'b0};
        end
        @(posedge clk); #1;
        bus16.s_sel = 1'b0; bus64.s_sel = 1'b0;
        d = (which == 0) ? {48'b0, bus16.s_dout} : bus64.s_dout;
    endtask

    // lat = cycle index (write cycle = 0) in which OPDONE first reads done; -1 on timeout
    task automatic start_wait(input int which, output int lat, output logic [63:0] first_st);
        logic [63:0] v;
        bus_wr(which, OFS_OPSTART, 64'd1);
        lat = -1;
        first_st = '1;
        for (int c = 1; c <= 3000; c++) begin
            bus_rd(which, OFS_OPDONE, v);
            if (c == 1) first_st = v;
            if (v[0]) begin
                lat = c;
                break;
            end
        end
    endtask

    // Product over (lo, op] with lo = max(low,1), truncated to 2*dw bits
    task automatic ref_model(input int unsigned dw, input logic [63:0] op, input logic [63:0] low,
                             output logic [127:0] res, output logic ovf, output int k);
        logic [191:0] w, mask;
        logic [63:0]  lo;
        lo   = (low == 0) ? 64'd1 : low;
        res  = 128'd1;
        ovf  = 1'b0;
        k    = 0;
        mask = {192{1'b1}} >> (192 - 2 * dw);
        for (longint unsigned i = lo + 1; i <= op; i++) begin
            w = {64'b0, res} * 192'(i);
            if ((w & ~mask) != 0) ovf = 1'b1;
            w = w & mask;
            res = w[127:0];
            k++;
        end
    endtask

    task automatic run16(input logic [63:0] op, input logic [63:0] low, output int lat,
                         output logic [63:0] first_st, output logic [63:0] h,
                         output logic [63:0] l, output logic [63:0] st);
        bus_wr(0, OFS_OPERAND, op);
        bus_wr(0, OFS_LOWER, low);
        start_wait(0, lat, first_st);
        bus_rd(0, OFS_RESULT_H, h);
        bus_rd(0, OFS_RESULT_L, l);
        bus_rd(0, OFS_OPDONE, st);
        bus_wr(0, OFS_OPCLEAR, 64'd1);
    endtask

    vec_t        tbl[6];
    int          lat, k;
    logic [63:0] fst, h, l, st, v;
    logic [127:0] res;
    logic        ovf;

    initial begin
        bus16.s_sel = 1'b0; bus16.s_wr = 1'b0; bus16.s_addr = '0; bus16.s_din = '0;
        bus64.s_sel = 1'b0; bus64.s_wr = 1'b0; bus64.s_addr = '0; bus64.s_din = '0;

        tbl[0] = '{op: 5,  low: 0, exp_h: 64'h0,    exp_l: 64'h0078, exp_st: 64'h1, exp_lat: 74};
        tbl[1] = '{op: 12, low: 0, exp_h: 64'h1C8C, exp_l: 64'hFC00, exp_st: 64'h1, exp_lat: 200};
        tbl[2] = '{op: 13, low: 0, exp_h: 64'h7328, exp_l: 64'hCC00, exp_st: 64'h5, exp_lat: 218};
        tbl[3] = '{op: 0,  low: 0, exp_h: 64'h0,    exp_l: 64'h0001, exp_st: 64'h1, exp_lat: 2};
        tbl[4] = '{op: 1,  low: 0, exp_h: 64'h0,    exp_l: 64'h0001, exp_st: 64'h1, exp_lat: 2};
        tbl[5] = '{op: 10, low: 7, exp_h: 64'h0,    exp_l: 64'h02D0, exp_st: 64'h1, exp_lat: 56};

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        chk("reset_dout", bus16.s_dout, 0);
        chk("reset_irq", bus16.interrupt, 0);
        bus_rd(0, OFS_OPDONE, v);   chk("reset_opdone", v, 0);
        bus_rd(0, OFS_RESULT_L, v); chk("reset_result_l", v, 1);
        bus_rd(0, OFS_RESULT_H, v); chk("reset_result_h", v, 0);
        bus_wr(0, 5'd7, 64'hFFFF);
        bus_rd(0, 5'd7, v);         chk("unmapped_read", v, 0);

        for (int i = 0; i < 6; i++) begin
            run16(tbl[i].op, tbl[i].low, lat, fst, h, l, st);
            chk($sformatf("tbl%0d_latency", i), lat, tbl[i].exp_lat);
            chk($sformatf("tbl%0d_busy", i), fst, (tbl[i].exp_lat == 2) ? 64'h2 : 64'h2);
            chk($sformatf("tbl%0d_result_h", i), h, tbl[i].exp_h);
            chk($sformatf("tbl%0d_result_l", i), l, tbl[i].exp_l);
            chk($sformatf("tbl%0d_opdone", i), st, tbl[i].exp_st);
        end

        for (int t = 0; t < 8; t++) begin
            logic [63:0] rop, rlow;
            rop  = 64'($urandom_range(0, 15));
            rlow = 64'($urandom_range(0, 10));
            ref_model(16, rop, rlow, res, ovf, k);
            run16(rop, rlow, lat, fst, h, l, st);
            chk($sformatf("rnd%0d_latency", t), lat, 2 + k * 18);
            chk($sformatf("rnd%0d_result_h", t), h, {48'b0, res[31:16]});
            chk($sformatf("rnd%0d_result_l", t), l, {48'b0, res[15:0]});
            chk($sformatf("rnd%0d_opdone", t), st, {61'b0, ovf, 2'b01});
        end

        // interrupt follows done and drops the cycle after OPCLEAR
        bus_wr(0, OFS_INTREN, 64'd1);
        bus_wr(0, OFS_OPERAND, 64'd4);
        bus_wr(0, OFS_LOWER, 64'd0);
        bus_wr(0, OFS_OPSTART, 64'd1);
        chk("irq_while_busy", bus16.interrupt, 0);
        lat = -1;
        for (int c = 0; c < 200; c++) begin
            if (bus16.interrupt) begin lat = c; break; end
            @(posedge clk); #1;
        end
        bus_rd(0, OFS_OPDONE, v);
        chk("irq_raised", bus16.interrupt, 1);
        chk("irq_with_done", v, 1);
        bus_wr(0, OFS_OPCLEAR, 64'd1);
        chk("irq_cleared", bus16.interrupt, 0);
        bus_rd(0, OFS_RESULT_L, v); chk("clear_result_l", v, 1);
        bus_rd(0, OFS_INTREN, v);   chk("clear_keeps_intren", v, 1);
        bus_wr(0, OFS_INTREN, 64'd0);

        // abort mid-multiply; writes while busy are ignored
        bus_wr(0, OFS_OPERAND, 64'd8);
        bus_wr(0, OFS_OPSTART, 64'd1);
        repeat (10) @(posedge clk);
        #1;
        bus_wr(0, OFS_OPERAND, 64'd3);
        bus_wr(0, OFS_OPSTART, 64'd1);
        bus_rd(0, OFS_OPDONE, v);   chk("abort_busy_before", v, 2);
        bus_wr(0, OFS_OPCLEAR, 64'd1);
        bus_rd(0, OFS_OPDONE, v);   chk("abort_idle_after", v, 0);
        bus_rd(0, OFS_OPERAND, v);  chk("abort_operand_kept", v, 8);
        start_wait(0, lat, fst);
        chk("restart_latency", lat, 2 + 7 * 18);
        bus_rd(0, OFS_RESULT_L, v); chk("restart_result_l", v, 64'h9D80);
        bus_rd(0, OFS_RESULT_H, v); chk("restart_result_h", v, 0);

        // DW=64: 20! fits in the low word
        ref_model(64, 20, 0, res, ovf, k);
        bus_wr(1, OFS_OPERAND, 64'd20);
        start_wait(1, lat, fst);
        chk("w64_latency", lat, 2 + k * 66);
        bus_rd(1, OFS_RESULT_L, v); chk("w64_result_l", v, 64'h21C3677C82B40000);
        bus_rd(1, OFS_RESULT_H, v); chk("w64_result_h", v, 0);
        chk("w64_model", res, {64'b0, 64'h21C3677C82B40000});
        bus_rd(1, OFS_OPDONE, v);   chk("w64_opdone", v, 1);

        // asynchronous reset mid-run
        bus_wr(1, OFS_INTREN, 64'd1);
        bus_wr(1, OFS_OPCLEAR, 64'd1);
        bus_wr(1, OFS_OPSTART, 64'd1);
        repeat (30) @(posedge clk);
        #1;
        bus_rd(1, OFS_RESULT_L, v); chk("w64_midrun_result", v, 1);
        #3 reset_n = 1'b0;
        #1;
        chk("async_reset_dout", bus64.s_dout, 0);
        chk("async_reset_irq", bus64.interrupt, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        bus_rd(1, OFS_OPDONE, v);   chk("post_reset_opdone", v, 0);
        bus_rd(1, OFS_INTREN, v);   chk("post_reset_intren", v, 0);
        bus_rd(1, OFS_OPERAND, v);  chk("post_reset_operand", v, 0);
        bus_rd(1, OFS_RESULT_L, v); chk("post_reset_result_l", v, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
